// File: rtl/uart_stream_adapter_pkg.sv
// rtl/uart_stream_adapter_pkg.sv - shared constants and FSM encoding for uart_stream_adapter
package uart_stream_adapter_pkg;

    localparam logic [31:0] UART_RX_EMPTY = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_DIVWR = 2'd1,
        ST_RUN   = 2'd2
    } adapter_state_t;

    // simpleuart returns all-ones when empty, otherwise a zero-extended byte
    function automatic logic rx_byte_present(input logic [31:0] dat_do);
        return (dat_do != UART_RX_EMPTY) && (dat_do[31:8] == 24'd0);
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - DEPTHx8 synchronous byte FIFO with occupancy level
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

    // A full FIFO refuses the push even if it pops in the same cycle
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_stream_adapter.sv
// rtl/uart_stream_adapter.sv - byte-stream initiator for the simpleuart register port
module uart_stream_adapter
    import uart_stream_adapter_pkg::*;
#(
    parameter int          DEPTH    = 16,
    parameter logic [31:0] DIV_INIT = 32'd0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    input  logic [7:0]               tx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [7:0]               rx_data,
    output logic [3:0]               uart_div_we,
    output logic [31:0]              uart_div_di,
    output logic                     uart_dat_we,
    output logic [7:0]               uart_dat_di,
    input  logic                     uart_dat_wait,
    output logic                     uart_dat_re,
    input  logic [31:0]              uart_dat_do,
    output logic [$clog2(DEPTH):0]   tx_level,
    output logic [$clog2(DEPTH):0]   rx_level,
    output logic                     rx_stall,
    input  logic                     clr_stall
);
    adapter_state_t state_q, state_d;
    logic [3:0]     div_we_q, div_we_d;
    logic [31:0]    div_di_q, div_di_d;
    logic           rx_stall_q, rx_stall_d;

    logic           run;
    logic           tx_full, tx_empty, tx_pop;
    logic [7:0]     tx_head;
    logic           rx_full, rx_empty, rx_present;
    logic [7:0]     rx_head;

    uart_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (tx_valid),
        .pop    (tx_pop),
        .din    (tx_data),
        .dout   (tx_head),
        .full   (tx_full),
        .empty  (tx_empty),
        .level  (tx_level)
    );

    uart_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (uart_dat_re),
        .pop    (rx_ready),
        .din    (uart_dat_do[7:0]),
        .dout   (rx_head),
        .full   (rx_full),
        .empty  (rx_empty),
        .level  (rx_level)
    );

    assign run         = (state_q == ST_RUN);
    assign tx_ready    = !tx_full;
    assign uart_dat_we = run && !tx_empty;
    assign uart_dat_di = uart_dat_we ? tx_head : 8'h00;
    assign tx_pop      = uart_dat_we && !uart_dat_wait;

    // The UART drops its byte at the edge after a read, so each read is a one-cycle pulse
    assign rx_present  = run && rx_byte_present(uart_dat_do);
    assign uart_dat_re = rx_present && !rx_full;
    assign rx_valid    = !rx_empty;
    assign rx_data     = rx_valid ? rx_head : 8'h00;

    assign uart_div_we = div_we_q;
    assign uart_div_di = div_di_q;
    assign rx_stall    = rx_stall_q;

    always_comb begin
        state_d  = state_q;
        div_we_d = 4'h0;
        div_di_d = 32'h0;
        case (state_q)
            ST_INIT: begin
                if (DIV_INIT != 32'd0) begin
                    state_d  = ST_DIVWR;
                    div_we_d = 4'hF;
                    div_di_d = DIV_INIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DIVWR: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        rx_stall_d = rx_stall_q;
        if (rx_present && rx_full) begin
            rx_stall_d = 1'b1;
        end else if (clr_stall) begin
            rx_stall_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_INIT;
            div_we_q   <= 4'h0;
            div_di_q   <= 32'h0;
            rx_stall_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_we_q   <= div_we_d;
            div_di_q   <= div_di_d;
            rx_stall_q <= rx_stall_d;
        end
    end

endmodule

// File: tb/tb_uart_stream_adapter.sv
// tb/tb_uart_stream_adapter.sv - self-checking bench for uart_stream_adapter
module tb_uart_stream_adapter;
    import uart_stream_adapter_pkg::*;

    localparam int          DEPTH = 16;
    localparam logic [31:0] DIV   = 32'd104;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   tx_valid, tx_ready;
    logic [7:0]             tx_data;
    logic                   rx_valid, rx_ready;
    logic [7:0]             rx_data;
    logic [3:0]             uart_div_we;
    logic [31:0]            uart_div_di;
    logic                   uart_dat_we;
    logic [7:0]             uart_dat_di;
    logic                   uart_dat_wait;
    logic                   uart_dat_re;
    logic [31:0]            uart_dat_do;
    logic [$clog2(DEPTH):0] tx_level, rx_level;
    logic                   rx_stall, clr_stall;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        tx_valid;
        logic [7:0]  tx_data;
        logic        wait_i;
        logic [31:0] dat_do;
        logic        rx_ready;
        logic        exp_we;
        logic [7:0]  exp_di;
        logic        exp_re;
        logic        exp_rx_valid;
        logic [7:0]  exp_rx_data;
        int          exp_tx_level;
        int          exp_rx_level;
    } vec_t;

    vec_t vecs[8];

    uart_stream_adapter #(.DEPTH(DEPTH), .DIV_INIT(DIV)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .uart_div_we   (uart_div_we),
        .uart_div_di   (uart_div_di),
        .uart_dat_we   (uart_dat_we),
        .uart_dat_di   (uart_dat_di),
        .uart_dat_wait (uart_dat_wait),
        .uart_dat_re   (uart_dat_re),
        .uart_dat_do   (uart_dat_do),
        .tx_level      (tx_level),
        .rx_level      (rx_level),
        .rx_stall      (rx_stall),
        .clr_stall     (clr_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        uart_dat_wait = 1'b0;
        uart_dat_do   = UART_RX_EMPTY;
        rx_ready      = 1'b0;
        clr_stall     = 1'b0;
    endtask

    // Called at the negedge where resetn has just been released (cycle 0)
    task automatic expect_divwr(input int lvl1);
        #1 check("div_we_c0", 32'(uart_div_we), 0);
        tick();
        tx_valid = 1'b0;
        #1;
        check("div_we_c1", 32'(uart_div_we), 'hF);
        check("div_di_c1", uart_div_di, DIV);
        check("dat_we_c1", 32'(uart_dat_we), 0);
        check("tx_level_c1", 32'(tx_level), 32'(lvl1));
        tick();
        #1;
        check("div_we_c2", 32'(uart_div_we), 0);
        check("div_di_c2", uart_div_di, 0);
    endtask

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic       pend, m_stall, e_we, e_re;
    logic [7:0] ub;

    initial begin
        vecs[0] = '{1'b1, 8'h11, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0};
        vecs[1] = '{1'b1, 8'h22, 1'b1, 32'h0000_003C, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1, 0};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 8'h3C, 2, 1};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 32'h0000_0100, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1, 0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 0};
        vecs[5] = '{1'b1, 8'hA5, 1'b1, 32'h0000_00FF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 0, 1};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hFF, 1, 1};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0};

        // Reset state; a present UART byte and a valid TX byte must both be ignored
        idle();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        tx_valid    = 1'b1;
        tx_data     = 8'h99;
        uart_dat_do = 32'h0000_0011;
        tick();
        tick();
        #1;
        check("rst_div_we", 32'(uart_div_we), 0);
        check("rst_div_di", uart_div_di, 0);
        check("rst_dat_we", 32'(uart_dat_we), 0);
        check("rst_dat_di", 32'(uart_dat_di), 0);
        check("rst_dat_re", 32'(uart_dat_re), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_tx_level", 32'(tx_level), 0);
        check("rst_rx_level", 32'(rx_level), 0);
        check("rst_rx_stall", 32'(rx_stall), 0);

        // Startup: a byte accepted in INIT is only issued once RUN begins in cycle 2
        @(negedge clk);
        idle();
        resetn   = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        expect_divwr(1);
        check("start_dat_we", 32'(uart_dat_we), 1);
        check("start_dat_di", 32'(uart_dat_di), 'h77);
        tick();
        #1 check("start_drained", 32'(tx_level), 0);
        tick();

        for (int i = 0; i < 8; i++) begin
            tx_valid      = vecs[i].tx_valid;
            tx_data       = vecs[i].tx_data;
            uart_dat_wait = vecs[i].wait_i;
            uart_dat_do   = vecs[i].dat_do;
            rx_ready      = vecs[i].rx_ready;
            #1;
            check($sformatf("vec%0d_tx_ready", i), 32'(tx_ready), 1);
            check($sformatf("vec%0d_we", i), 32'(uart_dat_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we)
                check($sformatf("vec%0d_di", i), 32'(uart_dat_di), 32'(vecs[i].exp_di));
            check($sformatf("vec%0d_re", i), 32'(uart_dat_re), 32'(vecs[i].exp_re));
            check($sformatf("vec%0d_rx_valid", i), 32'(rx_valid), 32'(vecs[i].exp_rx_valid));
            if (vecs[i].exp_rx_valid)
                check($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx_data));
            check($sformatf("vec%0d_tx_level", i), 32'(tx_level), 32'(vecs[i].exp_tx_level));
            check($sformatf("vec%0d_rx_level", i), 32'(rx_level), 32'(vecs[i].exp_rx_level));
            tick();
        end
        idle();

        // TX held by uart_dat_wait
        tx_valid      = 1'b1;
        tx_data       = 8'h55;
        uart_dat_wait = 1'b1;
        #1 check("txw_lvl0", 32'(tx_level), 0);
        tick();
        tx_data = 8'hA3;
        #1;
        check("txw_we_a", 32'(uart_dat_we), 1);
        check("txw_di_a", 32'(uart_dat_di), 'h55);
        check("txw_lvl1", 32'(tx_level), 1);
        tick();
        tx_valid      = 1'b0;
        uart_dat_wait = 1'b0;
        #1;
        check("txw_lvl2", 32'(tx_level), 2);
        check("txw_di_b", 32'(uart_dat_di), 'h55);
        tick();
        uart_dat_wait = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("txw_hold_we", 32'(uart_dat_we), 1);
            check("txw_hold_di", 32'(uart_dat_di), 'hA3);
            check("txw_hold_lvl", 32'(tx_level), 1);
            tick();
        end
        uart_dat_wait = 1'b0;
        #1 check("txw_last_di", 32'(uart_dat_di), 'hA3);
        tick();
        #1;
        check("txw_lvl_end", 32'(tx_level), 0);
        check("txw_we_end", 32'(uart_dat_we), 0);

        // TX full: 17th byte waits upstream until a pop frees a slot
        uart_dat_wait = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tx_valid = 1'b1;
            tx_data  = 8'(8'h40 + i);
            #1 check("txf_ready", 32'(tx_ready), 1);
            tick();
        end
        tx_data = 8'h50;
        #1;
        check("txf_full_ready", 32'(tx_ready), 0);
        check("txf_full_lvl", 32'(tx_level), DEPTH);
        tick();
        #1 check("txf_still_full", 32'(tx_ready), 0);
        tick();
        uart_dat_wait = 1'b0;
        #1;
        check("txf_pop_di", 32'(uart_dat_di), 'h40);
        check("txf_pop_ready", 32'(tx_ready), 0);
        tick();
        uart_dat_wait = 1'b1;
        #1;
        check("txf_free_ready", 32'(tx_ready), 1);
        check("txf_free_lvl", 32'(tx_level), DEPTH - 1);
        tick();
        tx_valid = 1'b0;
        #1 check("txf_refill_lvl", 32'(tx_level), DEPTH);
        uart_dat_wait = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            check("txf_drain_we", 32'(uart_dat_we), 1);
            check("txf_drain_di", 32'(uart_dat_di), (k < DEPTH - 1) ? 32'('h41 + k) : 'h50);
            tick();
        end
        #1 check("txf_empty", 32'(tx_level), 0);

        // RX single byte
        idle();
        uart_dat_do = 32'h0000_003C;
        #1 check("rx1_re", 32'(uart_dat_re), 1);
        tick();
        uart_dat_do = UART_RX_EMPTY;
        #1;
        check("rx1_re_gone", 32'(uart_dat_re), 0);
        check("rx1_valid", 32'(rx_valid), 1);
        check("rx1_data", 32'(rx_data), 'h3C);
        check("rx1_level", 32'(rx_level), 1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        #1 check("rx1_popped", 32'(rx_level), 0);

        // RX full, stall flag, set-beats-clear
        for (int i = 0; i < DEPTH; i++) begin
            uart_dat_do = 32'(i);
            #1 check("rxf_re", 32'(uart_dat_re), 1);
            tick();
        end
        uart_dat_do = 32'h0000_00AA;
        #1;
        check("rxf_blocked_re", 32'(uart_dat_re), 0);
        check("rxf_level", 32'(rx_level), DEPTH);
        check("rxf_stall_pre", 32'(rx_stall), 0);
        tick();
        #1;
        check("rxf_stall_set", 32'(rx_stall), 1);
        check("rxf_still_blocked", 32'(uart_dat_re), 0);
        rx_ready = 1'b1;
        #1 check("rxf_head", 32'(rx_data), 0);
        tick();
        rx_ready = 1'b0;
        #1;
        check("rxf_resume_re", 32'(uart_dat_re), 1);
        check("rxf_resume_lvl", 32'(rx_level), DEPTH - 1);
        tick();
        uart_dat_do = UART_RX_EMPTY;
        #1;
        check("rxf_refull", 32'(rx_level), DEPTH);
        check("rxf_stall_kept", 32'(rx_stall), 1);
        uart_dat_do = 32'h0000_00BB;
        clr_stall   = 1'b1;
        tick();
        uart_dat_do = UART_RX_EMPTY;
        clr_stall   = 1'b0;
        #1 check("rxf_set_wins", 32'(rx_stall), 1);
        clr_stall = 1'b1;
        tick();
        clr_stall = 1'b0;
        #1 check("rxf_cleared", 32'(rx_stall), 0);
        rx_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            check("rxf_drain_valid", 32'(rx_valid), 1);
            check("rxf_drain_data", 32'(rx_data), (k < DEPTH - 1) ? 32'(k + 1) : 'hAA);
            tick();
        end
        rx_ready = 1'b0;
        #1 check("rxf_empty", 32'(rx_level), 0);

        // Reset mid-TX at level 5, then the FSM repeats the divider write
        uart_dat_wait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_valid = 1'b1;
            tx_data  = 8'(i);
            tick();
        end
        tx_valid = 1'b0;
        #1;
        check("mid_lvl5", 32'(tx_level), 5);
        check("mid_we", 32'(uart_dat_we), 1);
        #1 resetn = 1'b0;
        #1;
        check("mid_rst_lvl", 32'(tx_level), 0);
        check("mid_rst_we", 32'(uart_dat_we), 0);
        tick();
        idle();
        resetn = 1'b1;
        expect_divwr(0);

        // Randomized run against a queue-based model
        pend    = 1'b0;
        m_stall = 1'b0;
        ub      = 8'h00;
        for (int c = 0; c < 800; c++) begin
            logic phase_fill;
            phase_fill    = ((c / 100) % 2) == 0;
            tx_valid      = ($urandom_range(0, 1) == 1);
            tx_data       = 8'($urandom);
            uart_dat_wait = phase_fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rx_ready      = phase_fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr_stall     = ($urandom_range(0, 15) == 0);
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1'b1;
                ub   = 8'($urandom);
            end
            uart_dat_do = pend ? {24'h0, ub} : UART_RX_EMPTY;
            #1;
            e_we = (txq.size() != 0);
            e_re = pend && (rxq.size() < DEPTH);
            check("rnd_tx_ready", 32'(tx_ready), 32'(txq.size() < DEPTH));
            check("rnd_we", 32'(uart_dat_we), 32'(e_we));
            if (e_we) check("rnd_di", 32'(uart_dat_di), 32'(txq[0]));
            check("rnd_re", 32'(uart_dat_re), 32'(e_re));
            check("rnd_rx_valid", 32'(rx_valid), 32'(rxq.size() != 0));
            if (rxq.size() != 0) check("rnd_rx_data", 32'(rx_data), 32'(rxq[0]));
            check("rnd_tx_level", 32'(tx_level), 32'(txq.size()));
            check("rnd_rx_level", 32'(rx_level), 32'(rxq.size()));
            check("rnd_stall", 32'(rx_stall), 32'(m_stall));
            if (pend && rxq.size() == DEPTH) m_stall = 1'b1;
            else if (clr_stall) m_stall = 1'b0;
            if (tx_valid && txq.size() < DEPTH) begin
                if (e_we && !uart_dat_wait) void'(txq.pop_front());
                txq.push_back(tx_data);
            end else if (e_we && !uart_dat_wait) begin
                void'(txq.pop_front());
            end
            if (e_re) begin
                if (rx_ready && rxq.size() != 0) void'(rxq.pop_front());
                rxq.push_back(ub);
                pend = 1'b0;
            end else if (rx_ready && rxq.size() != 0) begin
                void'(rxq.pop_front());
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
